hkg_stream_decryptor: RTL and testbench

Receiver-side consumer of the heterogeneous key pair `key1`/`key2` produced by `heterogeneous_key_gen`. It latches a key pair through a load handshake and seeds a xorshift32 keystream generator from it. It decrypts a valid/ready stream of 32-bit ciphertext words into plaintext words through an output FIFO. It sits between the key generator and the downstream data sink.

---
 rtl/hkg_stream_decryptor_if.sv | 42 ++++
 rtl/hkg_stream_decryptor.sv | 168 ++++++++++++++++
 tb/tb_hkg_stream_decryptor.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hkg_stream_decryptor_if.sv
// Handshake bundle for hkg_stream_decryptor: key-load port, ciphertext
// input stream, plaintext output stream and status.
// master = the side that drives keys/ciphertext and sinks plaintext.
// slave  = the decryptor itself.
interface hkg_stream_decryptor_if;
    logic [31:0] key1;
    logic [31:0] key2;
    logic        key_load;
    logic        key_ready;
    logic        key_err;

    logic [31:0] ct_data;
    logic        ct_valid;
    logic        ct_ready;

    logic [31:0] pt_data;
    logic        pt_valid;
    logic        pt_ready;

    logic [31:0] word_count;
    logic        busy;

    modport master (
        output key1, key2, key_load,
        input  key_ready, key_err,
        output ct_data, ct_valid,
        input  ct_ready,
        input  pt_data, pt_valid,
        output pt_ready,
        input  word_count, busy
    );

    modport slave (
        input  key1, key2, key_load,
        output key_ready, key_err,
        input  ct_data, ct_valid,
        output ct_ready,
        output pt_data, pt_valid,
        input  pt_ready,
        output word_count, busy
    );
endinterface

// File: rtl/hkg_stream_decryptor.sv
// hkg_stream_decryptor: latches a key pair, seeds a xorshift32 keystream and
// decrypts a 32-bit ciphertext stream into an output FIFO.
// Optional feature macro: HKG_KEYCHECK_EN (reject key pairs with key1 == key2).
module hkg_stream_decryptor #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    hkg_stream_decryptor_if.slave bus
);

    localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0] GoldenKs  = 32'h9E3779B9;
    localparam logic [PtrW:0] PtrOne  = {{PtrW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StSeed, StRun} state_e;

    state_e      state_q, state_d;
    logic [31:0] key1_q, key1_d;
    logic [31:0] key2_q, key2_d;
    logic [31:0] ks_q, ks_d;
    logic [31:0] wc_q, wc_d;
    logic        key_err_q, key_err_d;

    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic        fifo_empty, fifo_full;
    logic        key_ready, ct_ready;
    logic        key_bad, key_fire, key_ok, key_rej;
    logic        ct_fire, pop;
    logic [31:0] ks_a, ks_b, ks_c, seed_val, push_data;

`ifdef HKG_KEYCHECK_EN
    assign key_bad = (bus.key1 == bus.key2);
`else
    assign key_bad = 1'b0;
`endif

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    // Handshake readies: combinational from state, FIFO flags and key_load only.
    always_comb begin
        key_ready = 1'b0;
        ct_ready  = 1'b0;
        unique case (state_q)
            StIdle: key_ready = 1'b1;
            StRun: begin
                key_ready = fifo_empty;
                // A key request that is being taken this cycle blocks ciphertext.
                ct_ready  = !fifo_full && !(bus.key_load && key_ready);
            end
            default: begin
                key_ready = 1'b0;
                ct_ready  = 1'b0;
            end
        endcase
    end

    assign key_fire = bus.key_load && key_ready;
    assign key_ok   = key_fire && !key_bad;
    assign key_rej  = key_fire && key_bad;
    assign ct_fire  = bus.ct_valid && ct_ready;
    assign pop      = !fifo_empty && bus.pt_ready;

    // Keystream step and plaintext word for the current ks.
    always_comb begin
        ks_a      = ks_q ^ (ks_q << 13);
        ks_b      = ks_a ^ (ks_a >> 17);
        ks_c      = ks_b ^ (ks_b << 5);
        push_data = bus.ct_data ^ (ks_c + key2_q);
        // An all-zero state would lock xorshift at zero, so substitute a constant.
        seed_val  = ((key1_q ^ key2_q) == 32'd0) ? GoldenKs : (key1_q ^ key2_q);
    end

    // Control FSM next state plus key, keystream and counter updates.
    always_comb begin
        state_d   = state_q;
        key1_d    = key1_q;
        key2_d    = key2_q;
        ks_d      = ks_q;
        wc_d      = wc_q;
        key_err_d = key_rej;
        unique case (state_q)
            StIdle: begin
                if (key_ok) begin
                    key1_d  = bus.key1;
                    key2_d  = bus.key2;
                    state_d = StSeed;
                end
            end
            StSeed: begin
                ks_d    = seed_val;
                wc_d    = 32'd0;
                state_d = StRun;
            end
            StRun: begin
                if (key_ok) begin
                    key1_d  = bus.key1;
                    key2_d  = bus.key2;
                    state_d = StSeed;
                end else if (ct_fire) begin
                    ks_d = ks_c;
                    wc_d = wc_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO pointer next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (ct_fire) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            key1_q    <= 32'd0;
            key2_q    <= 32'd0;
            ks_q      <= 32'd0;
            wc_q      <= 32'd0;
            key_err_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            key1_q    <= key1_d;
            key2_q    <= key2_d;
            ks_q      <= ks_d;
            wc_q      <= wc_d;
            key_err_q <= key_err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so an empty FIFO presents pt_data = 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (ct_fire) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= push_data;
        end
    end

    assign bus.key_ready  = key_ready;
    assign bus.ct_ready   = ct_ready;
    assign bus.key_err    = key_err_q;
    assign bus.pt_valid   = !fifo_empty;
    assign bus.pt_data    = mem_q[rd_ptr_q[PtrW-1:0]];
    assign bus.word_count = wc_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_hkg_stream_decryptor.sv
// Scoreboard bench for hkg_stream_decryptor: stimulus pushes model-predicted
// plaintext into a queue, an independent monitor pops and compares.
module tb_hkg_stream_decryptor;

    logic clk = 1'b0;
    logic reset;

    hkg_stream_decryptor_if bus ();

    hkg_stream_decryptor #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_ks;
    logic [31:0] m_key2;
    logic [31:0] m_wc;
    int          err_seen = 0;
    int          err_exp  = 0;
    bit          rand_sink = 1'b0;
    bit          keycheck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference xorshift32 step.
    function automatic logic [31:0] xs32(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    task automatic model_accept(input logic [31:0] ct);
        m_ks = xs32(m_ks);
        exp_q.push_back(ct ^ (m_ks + m_key2));
        m_wc = m_wc + 32'd1;
    endtask

    // Monitor: compares every plaintext transfer against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.key_err === 1'b1) err_seen++;
            if (bus.pt_valid === 1'b1 && bus.pt_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pt: got %h expected no word", bus.pt_data);
                end else begin
                    check("pt_data", bus.pt_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.key_load = 1'b0;
        bus.ct_valid = 1'b0;
        bus.pt_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_key_ready", 32'(bus.key_ready), 32'd1);
        check("rst_key_err", 32'(bus.key_err), 32'd0);
        check("rst_ct_ready", 32'(bus.ct_ready), 32'd0);
        check("rst_pt_valid", 32'(bus.pt_valid), 32'd0);
        check("rst_pt_data", bus.pt_data, 32'd0);
        check("rst_word_count", bus.word_count, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        m_ks   = 32'd0;
        m_key2 = 32'd0;
        m_wc   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic try_word(input logic [31:0] ct, output bit acc);
        bus.ct_data  = ct;
        bus.ct_valid = 1'b1;
        @(negedge clk);
        acc = bus.ct_ready;
        if (acc) model_accept(ct);
        tick();
        bus.ct_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] ct);
        bit acc = 1'b0;
        int budget = 0;
        while (!acc && budget < 100) begin
            if (rand_sink) bus.pt_ready = 1'($urandom_range(0, 1));
            try_word(ct, acc);
            budget++;
        end
        if (!acc) begin
            n_checks++;
            $display("FAIL send_timeout: ct_ready got 0 expected 1");
        end
    endtask

    task automatic load_key(input logic [31:0] k1, input logic [31:0] k2);
        bit acc = 1'b0;
        bit rej;
        int budget = 0;
        bus.key1     = k1;
        bus.key2     = k2;
        bus.key_load = 1'b1;
        while (!acc && budget < 100) begin
            @(negedge clk);
            acc = bus.key_ready;
            if (acc && bus.ct_valid) check("collision_ct_ready", 32'(bus.ct_ready), 32'd0);
            if (!acc && bus.ct_valid && bus.ct_ready) model_accept(bus.ct_data);
            tick();
            budget++;
        end
        bus.key_load = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL key_timeout: key_ready got 0 expected 1");
            return;
        end
        rej = keycheck && (k1 == k2);
        if (rej) begin
            err_exp++;
        end else begin
            m_key2 = k2;
            m_ks   = ((k1 ^ k2) == 32'd0) ? 32'h9E3779B9 : (k1 ^ k2);
            m_wc   = 32'd0;
        end
        check("key_err_pulse", 32'(bus.key_err), 32'(rej));
        if (!rej) begin
            check("seed_busy", 32'(bus.busy), 32'd1);
            check("seed_key_ready", 32'(bus.key_ready), 32'd0);
            check("seed_ct_ready", 32'(bus.ct_ready), 32'd0);
        end
        tick();
        check("key_err_end", 32'(bus.key_err), 32'd0);
        if (!rej) check("wc_cleared", bus.word_count, 32'd0);
    endtask

    task automatic drain();
        int budget = 0;
        rand_sink    = 1'b0;
        bus.pt_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.pt_valid) && budget < 200) begin
            tick();
            budget++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_pt_valid", 32'(bus.pt_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] k1, k2, first, exp0;
        logic [31:0] words[6];
        bit acc;
        int idx;

`ifdef HKG_KEYCHECK_EN
        keycheck = 1'b1;
`else
        keycheck = 1'b0;
`endif
        bus.key1 = '0;
        bus.key2 = '0;
        bus.key_load = 1'b0;
        bus.ct_data = '0;
        bus.ct_valid = 1'b0;
        bus.pt_ready = 1'b0;
        reset = 1'b1;
        #2;
        do_reset();

        // Basic decrypt: known first keystream word.
        load_key(32'h00000001, 32'h00000000);
        bus.pt_ready = 1'b1;
        send_word(32'h00000000);
        check("basic_pt_valid", 32'(bus.pt_valid), 32'd1);
        check("basic_pt_data", bus.pt_data, 32'h00042021);
        check("basic_wc", bus.word_count, 32'd1);
        drain();

        // Random stream with bubbles and random sink stalls.
        rand_sink = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send_word($urandom);
        end
        drain();
        check("stream_wc", bus.word_count, m_wc);

        // Rekey while words are pending: key_ready waits for an empty FIFO.
        bus.pt_ready = 1'b0;
        send_word($urandom);
        send_word($urandom);
        check("pending_key_ready", 32'(bus.key_ready), 32'd0);
        fork
            load_key($urandom, $urandom);
            begin
                repeat (3) tick();
                bus.pt_ready = 1'b1;
            end
        join
        for (int i = 0; i < 10; i++) send_word($urandom);
        drain();

        // Zero seed (equal keys).
        do_reset();
        load_key(32'hA5A5A5A5, 32'hA5A5A5A5);
        if (keycheck) begin
            check("rej_busy", 32'(bus.busy), 32'd0);
            check("rej_ct_ready", 32'(bus.ct_ready), 32'd0);
            load_key(32'h12345678, 32'h0F0F0F0F);
        end
        bus.pt_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_word($urandom);
        drain();

        // Backpressure: six words offered to a four-entry FIFO.
        do_reset();
        k1 = $urandom;
        load_key(k1, k1 ^ 32'h00000001);
        bus.pt_ready = 1'b0;
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        idx = 0;
        for (int cyc = 0; cyc < 10 && idx < 6; cyc++) begin
            try_word(words[idx], acc);
            if (acc) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd4);
        bus.ct_data  = words[4];
        bus.ct_valid = 1'b1;
        bus.pt_ready = 1'b1;
        #1;
        check("bp_full_ct_ready", 32'(bus.ct_ready), 32'd0);
        check("bp_pt_valid", 32'(bus.pt_valid), 32'd1);
        check("bp_wc", bus.word_count, 32'd4);
        bus.ct_valid = 1'b0;
        send_word(words[4]);
        send_word(words[5]);
        drain();
        check("bp_wc_final", bus.word_count, 32'd6);

        // Rekey collision in RUN with an empty FIFO.
        bus.ct_data  = $urandom;
        bus.ct_valid = 1'b1;
        k1 = $urandom;
        load_key(k1, ~k1);
        send_word(bus.ct_data);
        drain();
        check("collision_wc", bus.word_count, 32'd1);

        // Reset mid-stream, then reload and replay the first word.
        k1 = $urandom;
        k2 = $urandom | 32'h1;
        if (k2 == k1) k2 = k1 ^ 32'h2;
        load_key(k1, k2);
        bus.pt_ready = 1'b0;
        first = $urandom;
        send_word(first);
        exp0 = exp_q[0];
        send_word($urandom);
        send_word($urandom);
        check("mid_pt_valid", 32'(bus.pt_valid), 32'd1);
        do_reset();
        load_key(k1, k2);
        bus.pt_ready = 1'b1;
        send_word(first);
        check("replay_pt_data", bus.pt_data, exp0);
        drain();

        check("key_err_count", 32'(err_seen), 32'(err_exp));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
